// File: rtl/counter_sched.sv
// Round-robin scheduler serializing inc/dec/clear/load operations from NREQ requesters onto one shared counter.
// Optional build macro COUNTER_SCHED_SAT_EN: inc/dec saturate instead of wrapping (ovf still pulses).
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [WIDTH*NREQ-1:0]  load_val,
  output logic [NREQ-1:0]        gnt,
  output logic [WIDTH-1:0]       count,
  output logic                   busy,
  output logic                   ovf
);

  // state | meaning
  // IDLE  | arbitrate among req, latch winner index/op/value
  // EXEC  | apply latched op to count
  // DONE  | gnt[idx] and ovf visible, last <= idx
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  state_t           state, state_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] val_q, val_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             ovf_nxt;
  logic             busy_nxt;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  int               cand;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    idx_nxt   = idx;
    op_nxt    = op_q;
    val_nxt   = val_q;
    count_nxt = count;
    gnt_nxt   = '0;
    ovf_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          idx_nxt   = win_idx;
          op_nxt    = op[2*int'(win_idx) +: 2];
          val_nxt   = load_val[WIDTH*int'(win_idx) +: WIDTH];
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_INC: begin
            if (&count) begin
              ovf_nxt = 1'b1;
`ifdef COUNTER_SCHED_SAT_EN
              count_nxt = count;
`else
              count_nxt = '0;
`endif
            end else begin
              count_nxt = count + WIDTH'(1);
            end
          end
          OP_DEC: begin
            if (count == '0) begin
              ovf_nxt = 1'b1;
`ifdef COUNTER_SCHED_SAT_EN
              count_nxt = count;
`else
              count_nxt = '1;
`endif
            end else begin
              count_nxt = count - WIDTH'(1);
            end
          end
          OP_CLR:  count_nxt = '0;
          default: count_nxt = val_q;
        endcase
        gnt_nxt[idx] = 1'b1;
        state_nxt    = DONE;
      end
      DONE: begin
        last_nxt  = idx;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= IW'(NREQ - 1);
      idx   <= '0;
      op_q  <= '0;
      val_q <= '0;
      count <= '0;
      gnt   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      idx   <= idx_nxt;
      op_q  <= op_nxt;
      val_q <= val_nxt;
      count <= count_nxt;
      gnt   <= gnt_nxt;
      ovf   <= ovf_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: a cycle-level reference model predicts each grant, a monitor checks it.
module tb_counter_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] load_val;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  ovf;

  counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .load_val(load_val),
    .gnt(gnt), .count(count), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    bit ov;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   m_last = NREQ - 1;
  int   m_cnt  = 0;
  int   m_busy = 0;
  bit   mon_en = 0;

  // Reference model: an operation occupies three cycles; the winner is the first
  // requesting index after the previous winner; result counted with plain integers.
  always @(posedge clk) begin
    int w;
    int o;
    int v;
    bit ov;
    exp_t e;
    cyc++;
    if (!reset_n) begin
      sb.delete();
      m_last = NREQ - 1;
      m_cnt  = 0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (req != 0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      o  = int'(op[2*w +: 2]);
      v  = int'(load_val[WIDTH*w +: WIDTH]);
      ov = 0;
      case (o)
        0: if (m_cnt == MAXV) begin
             ov = 1;
`ifndef COUNTER_SCHED_SAT_EN
             m_cnt = 0;
`endif
           end else m_cnt = m_cnt + 1;
        1: if (m_cnt == 0) begin
             ov = 1;
`ifndef COUNTER_SCHED_SAT_EN
             m_cnt = MAXV;
`endif
           end else m_cnt = m_cnt - 1;
        2: m_cnt = 0;
        default: m_cnt = v;
      endcase
      e.idx = w; e.cnt = m_cnt; e.ov = ov; e.due = cyc + 1;
      sb.push_back(e);
      m_last = w;
      m_busy = 2;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (busy !== (m_busy != 0)) begin
        fails++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_busy != 0));
      end
      if (gnt !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_gnt cyc=%0d gnt=%b count=%0d", cyc, gnt, count);
        end else begin
          e = sb.pop_front();
          if (gnt !== NREQ'(1 << e.idx) || count !== WIDTH'(e.cnt) || ovf !== e.ov || cyc != e.due) begin
            fails++;
            $display("FAIL grant cyc=%0d got gnt=%b count=%0d ovf=%b exp gnt=%b count=%0d ovf=%b due=%0d",
                     cyc, gnt, count, ovf, NREQ'(1 << e.idx), e.cnt, e.ov, e.due);
          end
        end
      end else begin
        checks++;
        if (ovf !== 1'b0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
          fails++;
          $display("FAIL missing_gnt cyc=%0d ovf=%b pending=%0d", cyc, ovf, sb.size());
          if (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [1:0] o, input logic [WIDTH-1:0] v);
    op[2*i +: 2] = o;
    load_val[WIDTH*i +: WIDTH] = v;
  endtask

  // Each requester in mask holds req until its grant, then drops it on the edge ending that grant
  task automatic run_ops(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] seen;
    int n;
    pend = mask; req = mask; n = 0;
    while (pend != 0 && n < 60) begin
      @(negedge clk); seen = gnt & pend;
      @(posedge clk); #1;
      pend = pend & ~seen; req = pend; n++;
    end
    checks++;
    if (pend != 0) begin
      fails++;
      $display("FAIL run_ops_timeout mask=%b pending=%b", mask, pend);
      req = '0;
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    checks++;
    if (count !== '0 || gnt !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s count=%0d gnt=%b busy=%b ovf=%b exp all 0", name, count, gnt, busy, ovf);
    end
  endtask

  initial begin
    int g;
    int n;
    reset_n = 1'b0; req = '0; op = '0; load_val = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1;
    check_reset_state("reset_state");
    @(posedge clk); #1;

    set_op(0, 2'b00, '0);
    run_ops(4'b0001);

    for (int i = 0; i < NREQ; i++) set_op(i, 2'b00, '0);
    req = '1; g = 0; n = 0;
    while (g < 12 && n < 80) begin
      @(negedge clk); if (gnt != 0) g++;
      n++;
    end
    @(posedge clk); #1 req = '0;
    checks++;
    if (g < 12) begin
      fails++;
      $display("FAIL round_robin_grants got=%0d exp=12", g);
    end
    drain();

    set_op(0, 2'b11, 4'd15); run_ops(4'b0001);
    set_op(0, 2'b00, '0);    run_ops(4'b0001);
    set_op(0, 2'b10, '0);    run_ops(4'b0001);
    set_op(0, 2'b01, '0);    run_ops(4'b0001);
    drain();

    set_op(0, 2'b00, '0); run_ops(4'b0001);
    set_op(1, 2'b10, '0);
    set_op(2, 2'b11, 4'd9);
    run_ops(4'b0110);
    drain();

    set_op(0, 2'b11, 4'd7);
    req = 4'b0001;
    @(posedge clk); #1;
    reset_n = 1'b0; req = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    check_reset_state("reset_mid_exec");
    @(posedge clk); #1;
    set_op(0, 2'b00, '0); set_op(1, 2'b00, '0);
    run_ops(4'b0011);
    drain();

    for (int c = 0; c < 400; c++) begin
      req      = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      op       = (2*NREQ)'($urandom());
      load_val = (WIDTH*NREQ)'($urandom());
      @(posedge clk); #1;
    end
    req = '0;
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one WIDTH-bit up/down counter register among NREQ requesters. Each requester posts an operation (increment, decrement, clear, load) with a req/gnt handshake. The block serializes the operations, applies them to the shared count, and acknowledges each with a one-cycle grant. It sits between the board-level input logic (debounced buttons, UART command decoder) and the display/LED path that consumes `count`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 4: counter width in bits.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  per-requester request level; bit i belongs to requester i.
- `op`  in  2*NREQ  per-requester opcode, bits [2i+1:2i]: 00 inc, 01 dec, 10 clear, 11 load.
- `load_val`  in  WIDTH*NREQ  per-requester load value, bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `gnt`  out  NREQ  one-hot completion pulse, one cycle.
- `count`  out  WIDTH  shared counter value.
- `busy`  out  1  high while the FSM is not in IDLE.
- `ovf`  out  1  one-cycle pulse when an inc from all-ones or a dec from zero is executed.

## Operation
- The FSM has three states: IDLE, EXEC and DONE.
- **IDLE**
  - If `req` is nonzero, pick the winner by round robin: search starts at `last+1` (mod NREQ) and takes the first set bit.
  - Latch the winner index, its `op` and its `load_val`, then go to EXEC.
  - If `req` is zero, stay in IDLE.
- **EXEC:** apply the latched op to `count`, then go to DONE.
  - inc: `count+1`.
  - dec: `count-1`.
  - clear: 0.
  - load: the latched value.
- **DONE:** assert `gnt[idx]`, set `last <= idx`, then return to IDLE.
- Arithmetic is modulo 2^WIDTH: inc from all-ones gives 0, dec from 0 gives all-ones.
  - `ovf` pulses in the DONE cycle of a wrapping inc or dec.
  - clear and load never raise `ovf`.
- `op` and `load_val` are sampled only in the IDLE arbitration cycle. They need to be stable only in that cycle. Changes afterwards do not affect the operation in flight.
- A requester that keeps `req` high after its `gnt` posts a new operation. That operation competes fairly in the next IDLE cycle.
- A requester that drops `req` before being granted withdraws its request, unless arbitration has already latched it. A latched operation always completes and is always granted.
- Exactly one `gnt` bit is high, and only in DONE. `gnt` is all zeros otherwise.
- **Reset** (any state, mid-operation included) sets:
  - state to IDLE;
  - `count`, `gnt`, `ovf` and `busy` to 0;
  - `last` to NREQ-1, so requester 0 wins first;
  - latched index, op and value to 0.
  - An in-flight operation is discarded and is not granted.

## Timing
- Cycle 0 (IDLE): `req[i]` is sampled and arbitration is performed.
- Cycle 1 (EXEC): `busy` is high.
- Cycle 2 (DONE): `busy` is high and `gnt[i]` is high. The new `count` value and `ovf` are valid in this cycle.
- Latency is 2 cycles from the sampling edge to `gnt`. Maximum throughput is one operation per 3 cycles.
- Handshake rule: a requester wanting a single operation deasserts `req` on the clock edge that ends its `gnt` cycle. The following IDLE cycle then sees it low.
- Worst-case wait for a continuously requesting master is 3*NREQ cycles after its previous grant. This follows from round-robin fairness.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `COUNTER_SCHED_SAT_EN`.
- **Defined:** inc and dec saturate.
  - inc at all-ones holds all-ones.
  - dec at 0 holds 0.
  - `ovf` still pulses in DONE, flagging the blocked operation.
- **Undefined:** inc and dec wrap modulo 2^WIDTH as described in Operation.

## Test plan
- Reset, then `req=0001`, `op0=00`, held for a single operation. Expect `gnt=0001` exactly 2 cycles after the sampling edge and `count=1`. `busy` is high for 2 cycles.
- `req=1111` held continuously, all ops inc. Expect grant order 0,1,2,3,0,… with one `gnt` every 3 cycles and `count` incrementing by 1 per grant.
- `count=15`, inc → `count=0` with an `ovf` pulse in DONE. With `COUNTER_SCHED_SAT_EN` defined: `count=15` with an `ovf` pulse.
- `count=0`, dec → `count=15` with `ovf`. With the macro defined: `count=0` with `ovf`.
- Requester 2 loads 9 while requester 1 issues clear, both requested in the same cycle with `last=0`. Expect `gnt=0010` and `count=0` first, then `gnt=0100` and `count=9`.
- Assert `reset_n=0` during EXEC of a load of 7. Expect no `gnt`, `count=0`, state IDLE, and requester 0 winning the next arbitration.
